// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the shift-and-add multiplier slice.
//   - default word / counter widths
//   - ALU operation codes understood by alu_mul_sequencer_alu
//   - sequencer state encoding (2'd3 is unused and decodes back to IDLE)
package alu_mul_sequencer_pkg;

    localparam int DEF_WORD_BITWIDTH = 32;
    localparam int DEF_CNT_BITWIDTH  = 6;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Request/response bundle between the execute stage and the multiplier.
//   start         request strobe, with multiplicand/multiplier as its payload
//   multiplicand  operand A, sampled only on an accepted start
//   multiplier    operand B, sampled only on an accepted start
//   busy          high while iterating; start is ignored (not queued) then
//   done          one-cycle completion pulse; product valid from this cycle
//   product       low WORD_BITWIDTH bits of A*B, held until the next done
//   state         sequencer state, exported for observation
//
// Handshake: start acts as "valid" and !busy acts as "ready". A request is
// accepted on a rising clk edge where start=1 and busy=0 (IDLE or DONE);
// the payload need only be stable at that edge. There is no back-pressure on
// the response side: done is a single-cycle pulse and product simply holds.
interface alu_mul_sequencer_if #(
    parameter int WORD_BITWIDTH = alu_mul_sequencer_pkg::DEF_WORD_BITWIDTH
) ();

    logic                          start;
    logic [WORD_BITWIDTH-1:0]      multiplicand;
    logic [WORD_BITWIDTH-1:0]      multiplier;
    logic                          busy;
    logic                          done;
    logic [WORD_BITWIDTH-1:0]      product;
    alu_mul_sequencer_pkg::state_t state;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product, state
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product, state
    );

endinterface

// File: rtl/alu_mul_sequencer_alu.sv
// Small combinational ALU shared with the execute stage.
//   operation  4-bit operation code (ALU_* in the package)
//   addend1    first operand
//   addend2    second operand
//   result     operation result, modulo 2**WORD_BITWIDTH; unknown codes give 0
module alu_mul_sequencer_alu
    import alu_mul_sequencer_pkg::*;
#(
    parameter int WORD_BITWIDTH = DEF_WORD_BITWIDTH
) (
    input  logic [3:0]               operation,
    input  logic [WORD_BITWIDTH-1:0] addend1,
    input  logic [WORD_BITWIDTH-1:0] addend2,
    output logic [WORD_BITWIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (operation)
            ALU_AND: result = addend1 & addend2;
            ALU_OR:  result = addend1 | addend2;
            ALU_ADD: result = addend1 + addend2;
            ALU_SUB: result = addend1 - addend2;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle shift-and-add multiplier: one add/shift step per clock using a
// single ALU in ADD mode. Returns the low WORD_BITWIDTH bits of A*B.
//   clk  rising-edge clock
//   rst  synchronous active-high reset; abandons any operation in flight
//   bus  slave side of alu_mul_sequencer_if (start/operands in,
//        busy/done/product/state out)
// CNT_BITWIDTH must satisfy 2**CNT_BITWIDTH > WORD_BITWIDTH.
module alu_mul_sequencer
    import alu_mul_sequencer_pkg::*;
#(
    parameter int WORD_BITWIDTH = DEF_WORD_BITWIDTH,
    parameter int CNT_BITWIDTH  = DEF_CNT_BITWIDTH
) (
    input  logic                clk,
    input  logic                rst,
    alu_mul_sequencer_if.slave  bus
);

    localparam logic [CNT_BITWIDTH-1:0] LAST_CNT = CNT_BITWIDTH'(WORD_BITWIDTH - 1);

    state_t                   state_r, state_next;
    logic [WORD_BITWIDTH-1:0] mcand_r, mplier_r, acc_r, product_r;
    logic [CNT_BITWIDTH-1:0]  cnt_r;
    logic [WORD_BITWIDTH-1:0] alu_sum, acc_next;
    logic                     accept, last_iter;

    alu_mul_sequencer_alu #(.WORD_BITWIDTH(WORD_BITWIDTH)) u_alu (
        .operation (ALU_ADD),
        .addend1   (acc_r),
        .addend2   (mcand_r),
        .result    (alu_sum)
    );

    assign acc_next = mplier_r[0] ? alu_sum : acc_r;

    // Stop as soon as no set multiplier bits remain after this step, so the
    // iteration count tracks the highest set bit of B rather than always W.
    assign last_iter = (mplier_r[WORD_BITWIDTH-1:1] == '0) || (cnt_r == LAST_CNT);

    // Requests are only taken when not iterating; DONE allows back-to-back.
    assign accept = bus.start && (state_r == IDLE || state_r == DONE);

    always_comb begin
        state_next = state_r;
        case (state_r)
            IDLE:    state_next = bus.start ? RUN : IDLE;
            RUN:     state_next = last_iter ? DONE : RUN;
            DONE:    state_next = bus.start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            mcand_r   <= '0;
            mplier_r  <= '0;
            acc_r     <= '0;
            cnt_r     <= '0;
            product_r <= '0;
        end else begin
            state_r <= state_next;
            if (accept) begin
                mcand_r  <= bus.multiplicand;
                mplier_r <= bus.multiplier;
                acc_r    <= '0;
                cnt_r    <= '0;
            end else if (state_r == RUN) begin
                acc_r    <= acc_next;
                mcand_r  <= mcand_r << 1;
                mplier_r <= mplier_r >> 1;
                cnt_r    <= cnt_r + CNT_BITWIDTH'(1);
                if (last_iter) begin
                    product_r <= acc_next;
                end
            end
        end
    end

    assign bus.busy    = (state_r == RUN);
    assign bus.done    = (state_r == DONE);
    assign bus.product = product_r;
    assign bus.state   = state_r;

endmodule
